alu_initiator: RTL

Command-side sequencer for the custom 4-bit ALU. It accepts operation commands on a valid/ready channel and drives opcode and operands to the combinational ALU. After a fixed settle time it captures the 8-bit ALU output `{Zero, Carry, Sign, Error, Result[3:0]}` and returns it on a valid/ready response channel. It sits between the host-facing pin logic and the ALU, and also supports chaining the previous result into operand A and counting ALU errors.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_initiator.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command-side initiator:
// opcode values, output flag bit positions and the initiator FSM encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_ROL  = 4'h4;
   localparam logic [3:0] OP_ROR  = 4'h5;
   localparam logic [3:0] OP_PENC = 4'h6;
   localparam logic [3:0] OP_GRAY = 4'h7;
   localparam logic [3:0] OP_MAJ  = 4'h8;
   localparam logic [3:0] OP_LWE  = 4'h9;
   localparam logic [3:0] OP_AND  = 4'hA;
   localparam logic [3:0] OP_OR   = 4'hB;
   localparam logic [3:0] OP_NOT  = 4'hC;
   localparam logic [3:0] OP_XOR  = 4'hD;
   localparam logic [3:0] OP_GT   = 4'hE;
   localparam logic [3:0] OP_EQ   = 4'hF;

   // Bit positions inside the 8-bit ALU output {Z,C,S,E,R[3:0]}
   localparam int FLAG_Z = 7;
   localparam int FLAG_C = 6;
   localparam int FLAG_S = 5;
   localparam int FLAG_E = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/alu_initiator.sv
// Command-side sequencer for the external 4-bit ALU: registers a command onto
// the ALU inputs, waits SETTLE_CYCLES, captures the ALU output and returns it.
module alu_initiator
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_opcode,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_chain,
   output logic [3:0] alu_opcode,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [7:0] alu_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] settle_cnt_q;
   logic [3:0] last_result_q;
   logic       accept;
   logic       capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      capture   = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == 4'd1) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = (state_q != ST_IDLE);

   // Operand stage: ALU inputs only move on command acceptance so the
   // combinational ALU output stays stable while a response is pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode   <= 4'h0;
         alu_a        <= 4'h0;
         alu_b        <= 4'h0;
         settle_cnt_q <= 4'h0;
      end else if (accept) begin
         alu_opcode   <= cmd_opcode;
         alu_a        <= cmd_chain ? last_result_q : cmd_a;
         alu_b        <= cmd_b;
         settle_cnt_q <= SETTLE_INIT;
      end else if (state_q == ST_SETTLE && settle_cnt_q != 4'd0) begin
         settle_cnt_q <= settle_cnt_q - 4'd1;
      end
   end

   // Capture stage: response, chain source and error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data      <= 8'h00;
         last_result_q <= 4'h0;
         err_count     <= 8'h00;
      end else if (capture) begin
         rsp_data      <= alu_out;
         last_result_q <= alu_out[3:0];
         if (alu_out[FLAG_E] && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule
